// File: rtl/ram_2rw_be.sv
// True dual-port byte-enable RAM with hardware clear FSM and read-valid strobes.
// Optional output register stage (read latency 2) enabled by defining RAM_2RW_BE_OUTREG_EN.
module ram_2rw_be #(
  parameter int              DW       = 16,
  parameter int              AW       = 10,
  parameter int              LW       = 8,
  parameter int              RDW_MODE = 0,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  output logic             ready_o,
  output logic             dbg_state_o,
  input  logic             en_a_i,
  input  logic             we_a_i,
  input  logic [DW/LW-1:0] be_a_i,
  input  logic [AW-1:0]    addr_a_i,
  input  logic [DW-1:0]    wdata_a_i,
  output logic [DW-1:0]    rdata_a_o,
  output logic             rvalid_a_o,
  input  logic             en_b_i,
  input  logic             we_b_i,
  input  logic [DW/LW-1:0] be_b_i,
  input  logic [AW-1:0]    addr_b_i,
  input  logic [DW-1:0]    wdata_b_i,
  output logic [DW-1:0]    rdata_b_o,
  output logic             rvalid_b_o
);
  localparam int NL    = DW / LW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            acc_a, acc_b;
  logic [NL-1:0]   wl_a, wl_b;
  logic [DW-1:0]   rd_a_d, rd_b_d;
  logic [DW-1:0]   rdata_a_q, rdata_b_q;
  logic            rvalid_a_q, rvalid_b_q;

  assign ready_o     = (state_q == ST_READY);
  assign dbg_state_o = state_q;
  assign acc_a       = ready_o & en_a_i;
  assign acc_b       = ready_o & en_b_i;
  assign wl_a        = {NL{acc_a & we_a_i}} & be_a_i;
  assign wl_b        = {NL{acc_b & we_b_i}} & be_b_i;

  // Clear walks every address once; a clear pulse in either state restarts the walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clear_i) begin
            cnt_q <= '0;
          end else if (cnt_q == {AW{1'b1}}) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          if (clear_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // Port B lanes are written first so port A overrides them on a same-address collision.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (wl_b[i]) mem[addr_b_i][i*LW +: LW] <= wdata_b_i[i*LW +: LW];
      end
      for (int i = 0; i < NL; i++) begin
        if (wl_a[i]) mem[addr_a_i][i*LW +: LW] <= wdata_a_i[i*LW +: LW];
      end
    end
  end

  always_comb begin
    rd_a_d = mem[addr_a_i];
    rd_b_d = mem[addr_b_i];
    if (RDW_MODE == 1) begin
      for (int i = 0; i < NL; i++) begin
        if (wl_a[i]) rd_a_d[i*LW +: LW] = wdata_a_i[i*LW +: LW];
        if (wl_b[i]) rd_b_d[i*LW +: LW] = wdata_b_i[i*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rvalid_a_q <= acc_a;
      rvalid_b_q <= acc_b;
      if (acc_a) rdata_a_q <= rd_a_d;
      if (acc_b) rdata_b_q <= rd_b_d;
    end
  end

`ifdef RAM_2RW_BE_OUTREG_EN
  logic [DW-1:0] rdata_a_q2, rdata_b_q2;
  logic          rvalid_a_q2, rvalid_b_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q2  <= '0;
      rdata_b_q2  <= '0;
      rvalid_a_q2 <= 1'b0;
      rvalid_b_q2 <= 1'b0;
    end else begin
      rvalid_a_q2 <= rvalid_a_q;
      rvalid_b_q2 <= rvalid_b_q;
      if (rvalid_a_q) rdata_a_q2 <= rdata_a_q;
      if (rvalid_b_q) rdata_b_q2 <= rdata_b_q;
    end
  end

  assign rdata_a_o  = rdata_a_q2;
  assign rdata_b_o  = rdata_b_q2;
  assign rvalid_a_o = rvalid_a_q2;
  assign rvalid_b_o = rvalid_b_q2;
`else
  assign rdata_a_o  = rdata_a_q;
  assign rdata_b_o  = rdata_b_q;
  assign rvalid_a_o = rvalid_a_q;
  assign rvalid_b_o = rvalid_b_q;
`endif

endmodule
